// File: rtl/detect_ctrl_if.sv
// PIPE receiver-detect and interval-timer signals shared by detect_ctrl and its link/PHY side.
interface detect_ctrl_if;
  logic       Enable;
  logic       RxElecIdle;
  logic       PhyStatus;
  logic [2:0] RxStatus;
  logic       TimeOut;
  logic       TimerStart;
  logic       TimerEnable;
  logic [2:0] TimerIntervalCode;
  logic       TxDetectRx;
  logic       TxElecIdle;
  logic       RxDetected;
  logic       DetectFail;

  modport master (
    input  Enable, RxElecIdle, PhyStatus, RxStatus, TimeOut,
    output TimerStart, TimerEnable, TimerIntervalCode,
           TxDetectRx, TxElecIdle, RxDetected, DetectFail
  );

  modport slave (
    output Enable, RxElecIdle, PhyStatus, RxStatus, TimeOut,
    input  TimerStart, TimerEnable, TimerIntervalCode,
           TxDetectRx, TxElecIdle, RxDetected, DetectFail
  );
endinterface

// File: rtl/detect_ctrl.sv
// Receiver-detect controller: quiet interval, PIPE detect request, retry with failure pulse.
module detect_ctrl #(
  parameter int unsigned MAX_ATTEMPTS   = 2,
  parameter int unsigned PHY_WAIT_LIMIT = 255
) (
  input logic            Pclk,
  input logic            Reset,
  detect_ctrl_if.master  pipe
);

  localparam int unsigned WW = (PHY_WAIT_LIMIT < 2) ? 1 : $clog2(PHY_WAIT_LIMIT + 1);
  localparam int unsigned AW = (MAX_ATTEMPTS < 2) ? 1 : $clog2(MAX_ATTEMPTS + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(PHY_WAIT_LIMIT - 1);
  localparam logic [AW-1:0] ATT_LAST  = AW'(MAX_ATTEMPTS - 1);

  typedef enum logic [2:0] {
    IDLE, Q_START, QUIET, ACTIVE, EVAL, DONE
  } state_t;

  state_t        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [AW-1:0] att_q, att_d;
  logic          res_q, res_d;

  always_ff @(posedge Pclk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      wait_q  <= '0;
      att_q   <= '0;
      res_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      att_q   <= att_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    att_d   = att_q;
    res_d   = res_q;
    if (!pipe.Enable) begin
      state_d = IDLE;
      wait_d  = '0;
      att_d   = '0;
      res_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE:    state_d = Q_START;
        Q_START: state_d = QUIET;
        QUIET: begin
          if (pipe.TimeOut || !pipe.RxElecIdle) begin
            state_d = ACTIVE;
            wait_d  = '0;
          end
        end
        ACTIVE: begin
          if (pipe.PhyStatus) begin
            res_d   = (pipe.RxStatus == 3'b011);
            state_d = EVAL;
          end else if (wait_q >= WAIT_LAST) begin
            res_d   = 1'b0;
            state_d = EVAL;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
        EVAL: begin
          if (res_q) begin
            att_d   = '0;
            state_d = DONE;
          end else begin
            // Reaching the limit wraps the count to zero so the next round starts fresh.
            att_d   = (att_q >= ATT_LAST) ? '0 : att_q + 1'b1;
            state_d = Q_START;
          end
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs depend only on registered state so reset drops them without a clock edge.
  always_comb begin
    pipe.TimerStart        = (state_q == Q_START);
    pipe.TimerEnable       = (state_q == QUIET);
    pipe.TimerIntervalCode = (state_q == Q_START || state_q == QUIET) ? 3'b001 : 3'b000;
    pipe.TxDetectRx        = (state_q == ACTIVE);
    pipe.TxElecIdle        = 1'b1;
    pipe.RxDetected        = (state_q == DONE);
    pipe.DetectFail        = (state_q == EVAL) && !res_q && (att_q >= ATT_LAST);
  end

endmodule

// File: tb/tb_detect_ctrl.sv
// Directed bench for detect_ctrl: detect success, retries, timeout, Enable drop and async reset.
module tb_detect_ctrl;

  logic Pclk;
  logic Reset;
  int   nchk;
  int   nerr;
  int   ts_cnt;
  int   tx_cnt;

  detect_ctrl_if dif ();

  detect_ctrl #(
    .MAX_ATTEMPTS   (2),
    .PHY_WAIT_LIMIT (8)
  ) dut (
    .Pclk  (Pclk),
    .Reset (Reset),
    .pipe  (dif.master)
  );

  initial Pclk = 1'b0;
  always #5 Pclk = ~Pclk;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Pclk);
      #1;
      if (dif.TimerStart) ts_cnt++;
      if (dif.TxDetectRx) tx_cnt++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_tstart"}, 8'(dif.TimerStart), 8'd0);
    check_val({tag, "_ten"},    8'(dif.TimerEnable), 8'd0);
    check_val({tag, "_code"},   8'(dif.TimerIntervalCode), 8'd0);
    check_val({tag, "_txdet"},  8'(dif.TxDetectRx), 8'd0);
    check_val({tag, "_txei"},   8'(dif.TxElecIdle), 8'd1);
    check_val({tag, "_rxdet"},  8'(dif.RxDetected), 8'd0);
    check_val({tag, "_fail"},   8'(dif.DetectFail), 8'd0);
  endtask

  initial begin
    nchk = 0; nerr = 0; ts_cnt = 0; tx_cnt = 0;
    Reset = 1'b0;
    dif.Enable = 1'b0; dif.RxElecIdle = 1'b1; dif.PhyStatus = 1'b0;
    dif.RxStatus = 3'b000; dif.TimeOut = 1'b0;
    #12;
    check_reset_outputs("rst");

    // Successful detection: TimeOut 20 cycles into QUIET, PhyStatus on 4th ACTIVE cycle
    Reset = 1'b1; dif.Enable = 1'b1;
    step(1);
    check_val("qs_tstart", 8'(dif.TimerStart), 8'd1);
    check_val("qs_ten",    8'(dif.TimerEnable), 8'd0);
    check_val("qs_code",   8'(dif.TimerIntervalCode), 8'd1);
    step(1);
    check_val("q_tstart", 8'(dif.TimerStart), 8'd0);
    check_val("q_ten",    8'(dif.TimerEnable), 8'd1);
    check_val("q_code",   8'(dif.TimerIntervalCode), 8'd1);
    step(19);
    check_val("q_hold_txdet", 8'(dif.TxDetectRx), 8'd0);
    dif.TimeOut = 1'b1;
    step(1);
    dif.TimeOut = 1'b0;
    check_val("act_txdet", 8'(dif.TxDetectRx), 8'd1);
    check_val("act_code",  8'(dif.TimerIntervalCode), 8'd0);
    check_val("act_ten",   8'(dif.TimerEnable), 8'd0);
    step(3);
    dif.PhyStatus = 1'b1; dif.RxStatus = 3'b011;
    step(1);
    dif.PhyStatus = 1'b0; dif.RxStatus = 3'b000;
    check_val("eval_txdet", 8'(dif.TxDetectRx), 8'd0);
    check_val("eval_rxdet", 8'(dif.RxDetected), 8'd0);
    check_val("ok_tx_cycles", 8'(tx_cnt), 8'd4);
    step(1);
    check_val("done_rxdet", 8'(dif.RxDetected), 8'd1);
    dif.PhyStatus = 1'b1;
    step(3);
    dif.PhyStatus = 1'b0;
    check_val("done_hold", 8'(dif.RxDetected), 8'd1);
    check_val("ok_ts_cycles", 8'(ts_cnt), 8'd1);
    check_val("done_txdet", 8'(dif.TxDetectRx), 8'd0);

    // Enable drop in DONE
    dif.Enable = 1'b0;
    step(1);
    check_val("dis_done_rxdet", 8'(dif.RxDetected), 8'd0);
    check_val("dis_done_ten",   8'(dif.TimerEnable), 8'd0);
    dif.Enable = 1'b1;
    step(1);
    check_val("reen_tstart", 8'(dif.TimerStart), 8'd1);

    // Attempt 1 fails; PhyStatus in QUIET ignored; TimeOut and RxElecIdle together
    step(1);
    dif.PhyStatus = 1'b1; dif.RxStatus = 3'b011;
    step(1);
    dif.PhyStatus = 1'b0; dif.RxStatus = 3'b000;
    check_val("q_phy_ignored", 8'(dif.TimerEnable), 8'd1);
    dif.TimeOut = 1'b1; dif.RxElecIdle = 1'b0;
    step(1);
    dif.TimeOut = 1'b0; dif.RxElecIdle = 1'b1;
    check_val("both_act", 8'(dif.TxDetectRx), 8'd1);
    step(1);
    check_val("both_single", 8'(dif.TxDetectRx), 8'd1);
    dif.PhyStatus = 1'b1;
    step(1);
    dif.PhyStatus = 1'b0;
    check_val("fail1_nopulse", 8'(dif.DetectFail), 8'd0);
    step(1);
    check_val("fail1_restart", 8'(dif.TimerStart), 8'd1);

    // Attempt 2: RxElecIdle drops 5 cycles into QUIET, then PhyStatus never comes
    step(1);
    step(5);
    check_val("q5_ten", 8'(dif.TimerEnable), 8'd1);
    dif.RxElecIdle = 1'b0;
    step(1);
    dif.RxElecIdle = 1'b1;
    check_val("eidle_act", 8'(dif.TxDetectRx), 8'd1);
    tx_cnt = 1;
    step(7);
    check_val("wait_last_txdet", 8'(dif.TxDetectRx), 8'd1);
    step(1);
    check_val("to_tx_cycles", 8'(tx_cnt), 8'd8);
    check_val("to_eval_txdet", 8'(dif.TxDetectRx), 8'd0);
    check_val("fail2_pulse", 8'(dif.DetectFail), 8'd1);
    step(1);
    check_val("fail2_pulse_end", 8'(dif.DetectFail), 8'd0);
    check_val("fail2_restart", 8'(dif.TimerStart), 8'd1);

    // Counter cleared after pulse: one more fail gives no pulse
    step(1);
    dif.TimeOut = 1'b1;
    step(1);
    dif.TimeOut = 1'b0; dif.PhyStatus = 1'b1;
    step(1);
    dif.PhyStatus = 1'b0;
    check_val("fail3_nopulse", 8'(dif.DetectFail), 8'd0);

    // Enable drop in ACTIVE with one failure pending clears the attempt count
    step(2);
    dif.TimeOut = 1'b1;
    step(1);
    dif.TimeOut = 1'b0;
    check_val("act2_txdet", 8'(dif.TxDetectRx), 8'd1);
    dif.Enable = 1'b0;
    step(1);
    check_val("dis_act_txdet", 8'(dif.TxDetectRx), 8'd0);
    check_val("dis_act_rxdet", 8'(dif.RxDetected), 8'd0);
    dif.Enable = 1'b1;
    step(1);
    check_val("reen2_tstart", 8'(dif.TimerStart), 8'd1);
    step(1);
    dif.TimeOut = 1'b1;
    step(1);
    dif.TimeOut = 1'b0; dif.PhyStatus = 1'b1;
    step(1);
    dif.PhyStatus = 1'b0;
    check_val("att_cleared_nopulse", 8'(dif.DetectFail), 8'd0);

    // Async reset mid-QUIET, then mid-ACTIVE
    step(2);
    check_val("q3_ten", 8'(dif.TimerEnable), 8'd1);
    #3 Reset = 1'b0;
    #1;
    check_reset_outputs("arst_q");
    #2 Reset = 1'b1;
    step(1);
    check_val("arst_resume_tstart", 8'(dif.TimerStart), 8'd1);
    step(1);
    dif.TimeOut = 1'b1;
    step(1);
    dif.TimeOut = 1'b0;
    check_val("act3_txdet", 8'(dif.TxDetectRx), 8'd1);
    #2 Reset = 1'b0;
    #1;
    check_val("arst_act_txdet", 8'(dif.TxDetectRx), 8'd0);
    #3 Reset = 1'b1;
    step(1);
    check_val("arst2_resume", 8'(dif.TimerStart), 8'd1);
    step(1);
    check_val("arst2_quiet", 8'(dif.TimerEnable), 8'd1);

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/detect_ctrl.md
DETECT_CTRL -- requirements
Module: detect_ctrl

Interface
REQ-001 Parameter MAX_ATTEMPTS, default 2: consecutive failed receiver detections before DetectFail pulses.
REQ-002 Parameter PHY_WAIT_LIMIT, default 255: cycles to wait for PhyStatus after TxDetectRx is asserted.
REQ-003 Pclk  input  1  single clock; all state updates on the rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 Enable  input  1  link is in Detect; low forces IDLE.
REQ-006 RxElecIdle  input  1  PIPE receiver electrical idle; 0 means activity seen.
REQ-007 PhyStatus  input  1  PIPE completion pulse for the receiver-detect operation.
REQ-008 RxStatus  input  3  PIPE status, sampled when PhyStatus=1; 3'b011 means receiver present.
REQ-009 TimeOut  input  1  expiry from the downstream interval timer.
REQ-010 TimerStart  output  1  clears the interval timer.
REQ-011 TimerEnable  output  1  lets the interval timer count.
REQ-012 TimerIntervalCode  output  3  interval select: 3'b001=12ms, 3'b000=0ms.
REQ-013 TxDetectRx  output  1  PIPE receiver-detect request.
REQ-014 TxElecIdle  output  1  transmitter electrical idle.
REQ-015 RxDetected  output  1  level; held high in DONE.
REQ-016 DetectFail  output  1  one-cycle pulse.

Function
REQ-017 The block SHALL use these states: IDLE, Q_START, QUIET, ACTIVE, EVAL, DONE.
REQ-018 IDLE: when Enable=1, the block SHALL go to Q_START on the next cycle.
REQ-019 Q_START lasts one cycle and SHALL drive TimerStart=1, TimerEnable=0 and TimerIntervalCode=3'b001, then go to QUIET.
REQ-020 QUIET SHALL drive TimerEnable=1 and TimerIntervalCode=3'b001.
- It SHALL exit to ACTIVE on the first cycle with TimeOut=1 or RxElecIdle=0.
- If both occur in the same cycle, the result SHALL be the same single transition.
REQ-021 ACTIVE SHALL drive TxDetectRx=1 every cycle.
- It SHALL increment a wait counter, which is cleared on entry.
- On PhyStatus=1, it SHALL latch (RxStatus==3'b011) into a result flag and go to EVAL.
- If the counter reaches PHY_WAIT_LIMIT without PhyStatus, it SHALL latch result=0 and go to EVAL.
REQ-022 A PhyStatus=1 seen outside ACTIVE SHALL be ignored.
REQ-023 EVAL lasts one cycle and SHALL drive TxDetectRx=0.
- result=1: clear the attempt counter and go to DONE.
- result=0: increment the attempt counter.
  - If the new count equals MAX_ATTEMPTS, pulse DetectFail for that one cycle and clear the counter.
  - In either case, go to Q_START.
REQ-024 DONE SHALL hold RxDetected=1 and stay in DONE until Enable=0.
REQ-025 TxElecIdle SHALL be 1 in every state; this block never drives data.
REQ-026 Enable=0 in any state SHALL, on the next edge:
- move the FSM to IDLE,
- clear the attempt counter, the wait counter and the result flag,
- deassert TimerEnable, TxDetectRx and RxDetected.
REQ-027 The counter widths SHALL be sized so that PHY_WAIT_LIMIT and MAX_ATTEMPTS are reached without wrap-around; counters SHALL saturate and never wrap.
REQ-028 All outputs SHALL be registered, or decoded from the registered state only, with no combinational path from any input to any output.
REQ-029 When TimerStart is not driven high, it SHALL be 0.
REQ-030 Outside Q_START and QUIET, TimerIntervalCode SHALL be 3'b000.

Reset
REQ-031 While Reset=0, asynchronously, the block SHALL hold:
- state=IDLE and all counters and flags at 0,
- TimerStart=0, TimerEnable=0, TimerIntervalCode=3'b000,
- TxDetectRx=0, TxElecIdle=1, RxDetected=0, DetectFail=0.
REQ-032 On the first edge after Reset rises with Enable=1, the block SHALL enter Q_START.
REQ-033 Reset asserted in the middle of ACTIVE SHALL drop TxDetectRx immediately, without waiting for a clock edge.

Verification
REQ-034 Enable=1, TimeOut rises 20 cycles after QUIET entry, PhyStatus arrives 3 cycles into ACTIVE with RxStatus=3'b011 -> TimerStart high for exactly 1 cycle, TxDetectRx high for 4 cycles, RxDetected=1 two cycles after PhyStatus and held.
REQ-035 Same flow with RxStatus=3'b000 on two consecutive attempts (MAX_ATTEMPTS=2) -> no DetectFail after the first EVAL; DetectFail pulses for 1 cycle at the second EVAL; FSM returns to Q_START.
REQ-036 No PhyStatus in ACTIVE, PHY_WAIT_LIMIT=8 -> TxDetectRx high for 8 cycles, then EVAL with result=0.
REQ-037 RxElecIdle drops 5 cycles into QUIET with TimeOut=0 -> ACTIVE entered on the next edge; same cycle with TimeOut=1 as well -> a single transition.
REQ-038 Enable dropped in DONE and in ACTIVE -> IDLE next cycle; RxDetected=0 and TxDetectRx=0; re-asserting Enable restarts at Q_START with the attempt count at 0.
REQ-039 Reset pulsed low mid-QUIET, not aligned to Pclk -> all outputs take their reset values immediately; normal flow resumes after release.
